// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between the
// CPU load/store port (0) and the debug/loader port (1).
//
// state  | meaning
// IDLE   | waiting for a request; grant decided here
// ACCESS | memory inputs presented; write acks here
// RDWAIT | waiting out the memory read latency
// RESP   | read data registered; read acks here
module data_mem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [1:0]       state;
  logic             grant;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             pick;
  logic             any_req;
  logic             done;

  // On a tie the port that did not win last time gets the memory.
  always_comb begin
    any_req = req0 | req1;
    pick    = (req0 && req1) ? ~last_grant : req1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick;
            last_grant <= pick;
            mem_addr   <= pick ? addr1 : addr0;
            mem_data   <= pick ? wdata1 : wdata0;
            mem_wren   <= pick ? we1 : we0;
            state      <= ACCESS;
          end else begin
            mem_wren <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_wren) begin
            mem_wren <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt   <= CNT_W'(READ_LAT - 1);
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (grant) rdata1 <= mem_q;
            else       rdata0 <= mem_q;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writes complete in ACCESS (mem_wren is still high there), reads in RESP.
  assign done = ((state == ACCESS) && mem_wren) || (state == RESP);
  assign ack0 = done && !grant;
  assign ack1 = done && grant;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: two instances (READ_LAT 1 and 2), each
// with a behavioural memory, checked through a completion scoreboard.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wren_cnt = 0;
  logic [10:0] wren_addr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a: READ_LAT = 1
  logic        a_req0 = 0, a_we0 = 0, a_req1 = 0, a_we1 = 0;
  logic [10:0] a_addr0 = '0, a_addr1 = '0;
  logic [31:0] a_wdata0 = '0, a_wdata1 = '0;
  logic        a_ack0, a_ack1, a_mem_wren, a_busy;
  logic [31:0] a_rdata0, a_rdata1, a_mem_data, a_mem_q;
  logic [10:0] a_mem_addr;

  // instance b: READ_LAT = 2, port 1 unused
  logic        b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
  logic [10:0] b_addr0 = '0, b_addr1 = '0;
  logic [31:0] b_wdata0 = '0, b_wdata1 = '0;
  logic        b_ack0, b_ack1, b_mem_wren, b_busy;
  logic [31:0] b_rdata0, b_rdata1, b_mem_data, b_mem_q;
  logic [10:0] b_mem_addr;

  data_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .READ_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
    .ack0(a_ack0), .rdata0(a_rdata0),
    .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
    .ack1(a_ack1), .rdata1(a_rdata1),
    .mem_wren(a_mem_wren), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
    .mem_q(a_mem_q), .busy(a_busy)
  );

  data_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .READ_LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
    .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
    .ack1(b_ack1), .rdata1(b_rdata1),
    .mem_wren(b_mem_wren), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .mem_q(b_mem_q), .busy(b_busy)
  );

  logic [31:0] mem_a [0:2047];
  logic [31:0] mem_b [0:2047];
  logic [31:0] b_q_stage;

  always @(posedge clk) begin
    if (a_mem_wren) mem_a[a_mem_addr] <= a_mem_data;
    a_mem_q <= mem_a[a_mem_addr];
  end

  always @(posedge clk) begin
    if (b_mem_wren) mem_b[b_mem_addr] <= b_mem_data;
    b_q_stage <= mem_b[b_mem_addr];
    b_mem_q   <= b_q_stage;
  end

  typedef struct {
    int          dut;
    int          port;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int p, input bit rd, input logic [31:0] data, input int c);
    exp_t e;
    e.dut = d; e.port = p; e.rd = rd; e.data = data; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drive(input int d, input int p, input logic r, input logic w,
                       input logic [10:0] a, input logic [31:0] wd);
    if (d == 0 && p == 0) begin a_req0 = r; a_we0 = w; a_addr0 = a; a_wdata0 = wd; end
    else if (d == 0)      begin a_req1 = r; a_we1 = w; a_addr1 = a; a_wdata1 = wd; end
    else if (p == 0)      begin b_req0 = r; b_we0 = w; b_addr0 = a; b_wdata0 = wd; end
    else                  begin b_req1 = r; b_we1 = w; b_addr1 = a; b_wdata1 = wd; end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the ack cycle.
  task automatic port_txn(input int d, input int p, input logic w,
                          input logic [10:0] a, input logic [31:0] wd);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    drive(d, p, 1'b1, w, a, wd);
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      got = (d == 0) ? (p == 0 ? a_ack0 : a_ack1) : (p == 0 ? b_ack0 : b_ack1);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_timeout: dut %0d port %0d got no ack, required ack within 64 cycles", d, p);
    end
    @(posedge clk);
    #1;
    drive(d, p, 1'b0, w, a, wd);
  endtask

  // Single-port transaction with nothing else pending: ack after 1 (write) or 2+READ_LAT (read).
  task automatic seq(input int d, input int p, input logic w, input logic [10:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    int lat;
    lat = w ? 1 : ((d == 0) ? 3 : 4);
    push(d, p, !w, exp_rd, cyc + lat);
    port_txn(d, p, w, a, wd);
  endtask

  // Scoreboard monitor
  initial begin
    logic        k0, k1;
    logic [31:0] r0, r1;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (a_mem_wren) begin
        wren_cnt++;
        wren_addr = a_mem_addr;
      end
      for (int d = 0; d < 2; d++) begin
        k0 = (d == 0) ? a_ack0 : b_ack0;
        k1 = (d == 0) ? a_ack1 : b_ack1;
        r0 = (d == 0) ? a_rdata0 : b_rdata0;
        r1 = (d == 0) ? a_rdata1 : b_rdata1;
        if (k0 || k1) begin
          chk("ack_exclusive", {31'd0, k0 & k1}, 32'd0);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL stray_ack: dut %0d ack0=%b ack1=%b, required no ack", d, k0, k1);
          end else begin
            e = sb.pop_front();
            chk("sb_dut", 32'(d), 32'(e.dut));
            chk("sb_port", {31'd0, k1}, 32'(e.port));
            chk("sb_ack_cycle", 32'(cyc), 32'(e.cyc));
            if (e.rd) chk("sb_rdata", k1 ? r1 : r0, e.data);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int w0;

    // reset values
    #1;
    chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_a_wren", {31'd0, a_mem_wren}, 32'd0);
    chk("rst_a_addr", {21'd0, a_mem_addr}, 32'd0);
    chk("rst_a_data", a_mem_data, 32'd0);
    chk("rst_a_acks", {30'd0, a_ack1, a_ack0}, 32'd0);
    chk("rst_a_rdata", a_rdata0 | a_rdata1, 32'd0);
    chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // port 0 write then read back
    w0 = wren_cnt;
    seq(0, 0, 1'b1, 11'h005, 32'hDEADBEEF, 32'h0);
    seq(0, 0, 1'b0, 11'h005, 32'h0, 32'hDEADBEEF);
    chk("t1_wren_cycles", 32'(wren_cnt - w0), 32'd1);
    chk("t1_wren_addr", {21'd0, wren_addr}, 32'h005);

    // preload through port 1, then simultaneous reads
    seq(0, 1, 1'b1, 11'h010, 32'h11, 32'h0);
    seq(0, 1, 1'b1, 11'h020, 32'h22, 32'h0);
    c = cyc;
    push(0, 0, 1'b1, 32'h11, c + 3);
    push(0, 1, 1'b1, 32'h22, c + 7);
    fork
      port_txn(0, 0, 1'b0, 11'h010, 32'h0);
      port_txn(0, 1, 1'b0, 11'h020, 32'h0);
      begin
        repeat (3) @(negedge clk);
        chk("t2_busy_c2", {31'd0, a_busy}, 32'd1);
        repeat (2) @(negedge clk);
        chk("t2_busy_idle_c4", {31'd0, a_busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t2_busy_c6", {31'd0, a_busy}, 32'd1);
      end
    join

    // both ports stream six writes each: grants alternate 0,1,0,1...
    c = cyc;
    for (int k = 0; k < 12; k++) push(0, k % 2, 1'b0, 32'h0, c + 1 + 2 * k);
    fork
      for (int i = 0; i < 6; i++) port_txn(0, 0, 1'b1, 11'(11'h100 + i), 32'hA000_0000 + 32'(i));
      for (int j = 0; j < 6; j++) port_txn(0, 1, 1'b1, 11'(11'h200 + j), 32'hB000_0000 + 32'(j));
    join
    for (int i = 0; i < 6; i++) seq(0, 0, 1'b0, 11'(11'h100 + i), 32'h0, 32'hA000_0000 + 32'(i));
    for (int j = 0; j < 6; j++) seq(0, 0, 1'b0, 11'(11'h200 + j), 32'h0, 32'hB000_0000 + 32'(j));

    // port 1 write to the top address wins the tie (last grant was 0), port 0 then reads it
    c = cyc;
    push(0, 1, 1'b0, 32'h0, c + 1);
    push(0, 0, 1'b1, 32'h0000_1234, c + 5);
    fork
      port_txn(0, 1, 1'b1, 11'h7FF, 32'h0000_1234);
      port_txn(0, 0, 1'b0, 11'h7FF, 32'h0);
      begin
        repeat (2) @(negedge clk);
        chk("t4_wren", {31'd0, a_mem_wren}, 32'd1);
        chk("t4_addr", {21'd0, a_mem_addr}, 32'h7FF);
        chk("t4_data", a_mem_data, 32'h0000_1234);
      end
    join

    // reset asserted while a read sits in RDWAIT
    c = cyc;
    drive(0, 0, 1'b1, 1'b0, 11'h005, 32'h0);
    repeat (3) @(negedge clk);
    chk("t5_busy_rdwait", {31'd0, a_busy}, 32'd1);
    rst_n = 1'b0;
    drive(0, 0, 1'b0, 1'b0, 11'h005, 32'h0);
    #1;
    chk("t5_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("t5_rst_wren", {31'd0, a_mem_wren}, 32'd0);
    chk("t5_rst_addr", {21'd0, a_mem_addr}, 32'd0);
    chk("t5_rst_data", a_mem_data, 32'd0);
    chk("t5_rst_rdata0", a_rdata0, 32'd0);
    chk("t5_rst_rdata1", a_rdata1, 32'd0);
    chk("t5_rst_acks", {30'd0, a_ack1, a_ack0}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_idle_after_rst", {31'd0, a_busy}, 32'd0);
    c = cyc;
    push(0, 0, 1'b0, 32'h0, c + 1);
    push(0, 1, 1'b0, 32'h0, c + 3);
    fork
      port_txn(0, 0, 1'b1, 11'h050, 32'h55);
      port_txn(0, 1, 1'b1, 11'h060, 32'h66);
    join

    // READ_LAT = 2 instance
    seq(1, 0, 1'b1, 11'h003, 32'hCAFE_0001, 32'h0);
    seq(1, 0, 1'b0, 11'h003, 32'h0, 32'hCAFE_0001);

    repeat (5) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory (2048 x 32, synchronous read) between two requesters.
- Port 0 is the CPU load/store path; port 1 is the debug/loader path, used to preload or inspect data memory over switches or serial.
- Sits between the cpu and data_mem instances in the top level.
- Uses a req/ack handshake per port, round-robin arbitration, and registered memory-side outputs.

Parameters:
ADDR_W, 11, word address width of data memory
DATA_W, 32, data word width
READ_LAT, 1, cycles from the memory sampling its address to mem_q being valid (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 request; held with fields stable until ack0
we0  input  1  port 0 write enable (1 = write, 0 = read)
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 write data
ack0  output  1  port 0 completion pulse, one cycle
rdata0  output  DATA_W  port 0 read data; valid with ack0 for reads
req1, we1, addr1, wdata1  input  1/1/ADDR_W/DATA_W  port 1 request fields, same rules as port 0
ack1, rdata1  output  1/DATA_W  port 1 completion and read data
mem_wren  output  1  to data_mem wren
mem_addr  output  ADDR_W  to data_mem address
mem_data  output  DATA_W  to data_mem data
mem_q  input  DATA_W  from data_mem q
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - state = IDLE, last_grant = 1 (so port 0 wins the first tie).
  - All outputs are 0: ack0, ack1, rdata0, rdata1, mem_wren, mem_addr, mem_data, busy.
  - Wait counter = 0.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last_grant.
  - On the grant edge: register mem_addr <= addr, mem_data <= wdata, mem_wren <= we; latch the granted port id into grant and last_grant; go to ACCESS.
  - If no req is high, stay in IDLE; mem_addr and mem_data hold their previous values; mem_wren = 0.
- ACCESS (one cycle; the memory samples its inputs at the end of this cycle):
  - Write: ack of the granted port = 1 in this cycle. Next edge: mem_wren <= 0, go to IDLE.
  - Read: mem_wren stays 0. Next edge: counter <= READ_LAT-1, go to RDWAIT.
- RDWAIT:
  - While counter != 0, decrement and stay.
  - When counter == 0, mem_q is valid this cycle: capture it into rdata of the granted port and go to RESP.
- RESP:
  - ack of the granted port = 1 for one cycle; rdata is stable.
  - Next edge: go to IDLE.
- Latency, counted from the cycle N in which IDLE sees req:
  - Write: ack in cycle N+1.
  - Read: ack in cycle N+2+READ_LAT (N+3 at default).
  - Throughput is one transaction in flight; a new grant can occur no earlier than the cycle after the ack.
- Handshake:
  - The requester drops req (or presents a new request) on the edge after the ack cycle.
  - The arbiter never samples req in the ack cycle.
  - Consecutive requests from the same port while the other port is idle are served back-to-back with no bubble beyond the IDLE cycle.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1…; neither port waits more than one transaction.
- Ack exclusivity: ack0 and ack1 are never high in the same cycle; at most one ack pulse per granted transaction.
- Read data hold: rdata0 and rdata1 each hold their last read value until the next read completion on that port. A write never changes rdata.
- Request withdrawn mid-transaction (protocol violation): the in-flight transaction completes and the ack still pulses.
- Reset mid-transaction: the transaction is abandoned; mem_wren drops immediately; no ack is produced after reset releases.
- Width rule: addresses and data pass through unmodified; no address range checking.

Test Plan:
- Port 0 writes 0xDEADBEEF to address 0x005, then reads 0x005 → mem_wren high exactly one cycle with mem_addr=0x005; ack0 one cycle after req; read ack0 three cycles after req with rdata0=0xDEADBEEF; ack1 never asserts.
- req0 and req1 rise in the same cycle, both reads (addresses 0x010 and 0x020 preloaded with 0x11 and 0x22) → port 0 is served first (rdata0=0x11), then port 1 (rdata1=0x22); busy stays high except the IDLE cycle between the two.
- Both ports hold req continuously for 6 writes each to distinct addresses → grant order 0,1,0,1,…; every address readback matches; no cycle with both acks high.
- Port 1 writes 0x1234 to 0x7FF while port 0 waits → mem_data=0x1234, mem_addr=0x7FF; ack1, then port 0 is granted in the next IDLE.
- rst_n pulsed low in RDWAIT → all outputs 0 immediately; after release, state is IDLE, no stray ack, and the next simultaneous request grants port 0.
- READ_LAT=2, read of 0x003 holding 0xCAFE0001 → ack0 four cycles after req with rdata0=0xCAFE0001.
